// File: rtl/fan_pkg.sv
// Shared definitions for the forwarding-adder-network (FAN) datapath.
// Provides the ctrl field layout, the result ctrl codes written into the
// merge slot, and the line-width helper used to size the lane vectors.
package fan_pkg;

  // Bit positions inside the 4-bit ctrl field {vld,keep,dir[1:0]}
  localparam int CTRL_VLD  = 3;
  localparam int CTRL_KEEP = 2;

  // Direction encodings carried in ctrl[1:0]
  localparam logic [1:0] DIR_L = 2'b01;
  localparam logic [1:0] DIR_R = 2'b10;

  // Ctrl codes stamped on a merged result line
  localparam logic [3:0] CODE_LR    = 4'b0111;
  localparam logic [3:0] CODE_L     = 4'b1001;
  localparam logic [3:0] CODE_R     = 4'b1010;
  localparam logic [3:0] CODE_PLAIN = 4'b1000;

  // Width of one lane: data words, then row tag, then ctrl on top
  function automatic int line_w(input int n_stack, input int dw_data,
                                input int dw_row, input int dw_ctrl);
    return n_stack * dw_data + dw_row + dw_ctrl;
  endfunction

endpackage

// File: rtl/fan_pipe_adder.sv
// N_STACK-wide word-wise adder with ADD_LAT output registers.
// Each DW_DATA word wraps on its own; no carry crosses word boundaries.
// ADD_LAT=0 degenerates to a purely combinational adder.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   en        pipeline advance enable (registers hold when low)
//   a, b      packed operand words, word w at [w*DW_DATA +: DW_DATA]
//   sum       packed word-wise sum, delayed by ADD_LAT cycles
module fan_pipe_adder #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32,
  parameter int ADD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_STACK*DW_DATA-1:0] a,
  input  logic [N_STACK*DW_DATA-1:0] b,
  output logic [N_STACK*DW_DATA-1:0] sum
);

  localparam int DW_SUM = N_STACK * DW_DATA;

  logic [DW_SUM-1:0] sum_s;

  // Independent per-word additions, each truncated to DW_DATA bits
  always_comb begin
    sum_s = '0;
    for (int w = 0; w < N_STACK; w++) begin
      sum_s[w*DW_DATA +: DW_DATA] = a[w*DW_DATA +: DW_DATA] + b[w*DW_DATA +: DW_DATA];
    end
  end

  generate
    if (ADD_LAT == 0) begin : g_comb
      assign sum = sum_s;
    end else begin : g_pipe
      logic [DW_SUM-1:0] stage_r [ADD_LAT];

      // Sum pipeline registers; frozen while the node is stalled
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < ADD_LAT; k++) begin
            stage_r[k] <= '0;
          end
        end else if (en) begin
          stage_r[0] <= sum_s;
          for (int k = 1; k < ADD_LAT; k++) begin
            stage_r[k] <= stage_r[k-1];
          end
        end
      end

      assign sum = stage_r[ADD_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fan_adder_node_pipe.sv
// Pipelined FAN node. Each half of the lanes is OR-reduced (vld-masked) to
// one candidate line; when both candidates are valid and share a row, their
// data words are added and the result is placed at the split boundary
// (OUT_LEFT = NUM_IN/2-1 or OUT_RIGHT = NUM_IN/2) with a ctrl code derived
// from the two dir fields. Other lanes survive only if their keep bit is set.
// Without a merge the beat passes through unchanged.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_data    NUM_IN packed lanes {ctrl,row,data}, lane i at [i*DW_LINE +: DW_LINE]
//   in_vld     input beat valid;  in_rdy  node can accept a beat
//   out_data   result lanes, same packing;  out_vld  result valid
//   out_rdy    downstream accepts the result
//   multi_hit  sticky flag: an accepted beat had >=2 vld lanes in one half
//   merge_cnt  saturating count of merges performed
//   cnt_clr    synchronous clear of merge_cnt and multi_hit
module fan_adder_node_pipe
  import fan_pkg::*;
#(
  parameter int NUM_IN   = 8,
  parameter int N_STACK  = 4,
  parameter int DW_DATA  = 32,
  parameter int DW_ROW   = 4,
  parameter int DW_CTRL  = 4,
  parameter int ADD_LAT  = 1,
  parameter int SYMMETRY = 0,
  parameter int CNT_W    = 16
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic [NUM_IN*line_w(N_STACK,DW_DATA,DW_ROW,DW_CTRL)-1:0]     in_data,
  input  logic                                                         in_vld,
  output logic                                                         in_rdy,
  output logic [NUM_IN*line_w(N_STACK,DW_DATA,DW_ROW,DW_CTRL)-1:0]     out_data,
  output logic                                                         out_vld,
  input  logic                                                         out_rdy,
  output logic                                                         multi_hit,
  output logic [CNT_W-1:0]                                             merge_cnt,
  input  logic                                                         cnt_clr
);

  localparam int DW_LINE   = line_w(N_STACK, DW_DATA, DW_ROW, DW_CTRL);
  localparam int DW_SUM    = N_STACK * DW_DATA;
  localparam int NW        = NUM_IN * DW_LINE;
  localparam int HALF      = NUM_IN / 2;
  localparam int OUT_LEFT  = HALF - 1;
  localparam int OUT_RIGHT = HALF;
  localparam int ROW_POS   = DW_SUM;
  localparam int DIR_POS   = DW_SUM + DW_ROW;
  localparam int VLD_POS   = DW_SUM + DW_ROW + CTRL_VLD;
  localparam int KEEP_POS  = DW_SUM + DW_ROW + CTRL_KEEP;
  // Sideband word: {vld, merge, row, code, slot_right, base lanes}
  localparam int SB_W      = 2 + DW_ROW + DW_CTRL + 1 + NW;

  logic               en_s;
  logic               accept_s;
  logic [DW_LINE-1:0] lane_s;
  logic [DW_SUM-1:0]  l_data_s, r_data_s;
  logic [DW_ROW-1:0]  l_row_s, r_row_s;
  logic [1:0]         l_dir_s, r_dir_s;
  logic               l_vld_s, r_vld_s, l_multi_s, r_multi_s;
  logic               merge_s, slot_right_s;
  logic [DW_CTRL-1:0] code_s;
  logic [NW-1:0]      base_s;
  logic [SB_W-1:0]    sb_in_s, sb_out_s;
  logic [DW_SUM-1:0]  sum_s;

  logic               vld_d_s, merge_d_s, slot_d_s;
  logic [DW_ROW-1:0]  row_d_s;
  logic [DW_CTRL-1:0] code_d_s;
  logic [NW-1:0]      base_d_s, result_s;

  logic               out_vld_r;
  logic [NW-1:0]      out_data_r;
  logic               multi_hit_r;
  logic [CNT_W-1:0]   merge_cnt_r;

  // The whole pipeline advances together whenever the output slot can move
  assign en_s     = !out_vld_r | out_rdy;
  assign accept_s = in_vld & en_s;
  assign in_rdy   = en_s;

  // Half selection, merge decision, slot/code choice and surviving lanes
  always_comb begin
    l_data_s = '0; r_data_s = '0;
    l_row_s  = '0; r_row_s  = '0;
    l_dir_s  = 2'b00; r_dir_s = 2'b00;
    l_vld_s  = 1'b0; r_vld_s = 1'b0;
    l_multi_s = 1'b0; r_multi_s = 1'b0;
    lane_s   = '0;
    code_s   = CODE_PLAIN;
    slot_right_s = 1'b0;
    base_s   = '0;

    // Each lane contributes only when its own vld bit is set
    for (int i = 0; i < NUM_IN; i++) begin
      lane_s = in_data[i*DW_LINE +: DW_LINE];
      if (i < HALF) begin
        l_multi_s = l_multi_s | (l_vld_s & lane_s[VLD_POS]);
        l_vld_s   = l_vld_s | lane_s[VLD_POS];
        l_data_s  = l_data_s | (lane_s[DW_SUM-1:0] & {DW_SUM{lane_s[VLD_POS]}});
        l_row_s   = l_row_s | (lane_s[ROW_POS +: DW_ROW] & {DW_ROW{lane_s[VLD_POS]}});
        l_dir_s   = l_dir_s | (lane_s[DIR_POS +: 2] & {2{lane_s[VLD_POS]}});
      end else begin
        r_multi_s = r_multi_s | (r_vld_s & lane_s[VLD_POS]);
        r_vld_s   = r_vld_s | lane_s[VLD_POS];
        r_data_s  = r_data_s | (lane_s[DW_SUM-1:0] & {DW_SUM{lane_s[VLD_POS]}});
        r_row_s   = r_row_s | (lane_s[ROW_POS +: DW_ROW] & {DW_ROW{lane_s[VLD_POS]}});
        r_dir_s   = r_dir_s | (lane_s[DIR_POS +: 2] & {2{lane_s[VLD_POS]}});
      end
    end

    merge_s = l_vld_s & r_vld_s & (l_row_s == r_row_s);

    if ((l_dir_s == DIR_L) && (r_dir_s == DIR_R)) begin
      code_s = CODE_LR;
      slot_right_s = 1'b0;
    end else if (l_dir_s == DIR_L) begin
      code_s = CODE_L;
      slot_right_s = 1'b1;
    end else if (r_dir_s == DIR_R) begin
      code_s = CODE_R;
      slot_right_s = 1'b0;
    end else begin
      code_s = CODE_PLAIN;
      slot_right_s = (SYMMETRY != 0);
    end

    // Both boundary slots start cleared on a merge; the result is inserted later
    for (int i = 0; i < NUM_IN; i++) begin
      lane_s = in_data[i*DW_LINE +: DW_LINE];
      if (!merge_s) begin
        base_s[i*DW_LINE +: DW_LINE] = lane_s;
      end else if ((i == OUT_LEFT) || (i == OUT_RIGHT)) begin
        base_s[i*DW_LINE +: DW_LINE] = '0;
      end else if (lane_s[KEEP_POS]) begin
        base_s[i*DW_LINE +: DW_LINE] = lane_s;
      end else begin
        base_s[i*DW_LINE +: DW_LINE] = '0;
      end
    end
  end

  assign sb_in_s = {in_vld, merge_s, l_row_s, code_s, slot_right_s, base_s};

  fan_pipe_adder #(
    .N_STACK (N_STACK),
    .DW_DATA (DW_DATA),
    .ADD_LAT (ADD_LAT)
  ) u_adder (
    .clk (clk),
    .rst (rst),
    .en  (en_s),
    .a   (l_data_s),
    .b   (r_data_s),
    .sum (sum_s)
  );

  // Sideband delay line matching the adder latency so everything stays aligned
  generate
    if (ADD_LAT == 0) begin : g_sb_comb
      assign sb_out_s = sb_in_s;
    end else begin : g_sb_pipe
      logic [SB_W-1:0] sb_r [ADD_LAT];

      // Sideband registers, advanced with the same enable as the adder
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < ADD_LAT; k++) begin
            sb_r[k] <= '0;
          end
        end else if (en_s) begin
          sb_r[0] <= sb_in_s;
          for (int k = 1; k < ADD_LAT; k++) begin
            sb_r[k] <= sb_r[k-1];
          end
        end
      end

      assign sb_out_s = sb_r[ADD_LAT-1];
    end
  endgenerate

  assign base_d_s  = sb_out_s[NW-1:0];
  assign slot_d_s  = sb_out_s[NW];
  assign code_d_s  = sb_out_s[NW+1 +: DW_CTRL];
  assign row_d_s   = sb_out_s[NW+1+DW_CTRL +: DW_ROW];
  assign merge_d_s = sb_out_s[SB_W-2];
  assign vld_d_s   = sb_out_s[SB_W-1];

  // Drop the merged line into its boundary slot
  always_comb begin
    result_s = base_d_s;
    if (merge_d_s) begin
      if (slot_d_s) begin
        result_s[OUT_RIGHT*DW_LINE +: DW_LINE] = {code_d_s, row_d_s, sum_s};
      end else begin
        result_s[OUT_LEFT*DW_LINE +: DW_LINE] = {code_d_s, row_d_s, sum_s};
      end
    end else begin
      result_s = base_d_s;
    end
  end

  // Output register; bubbles leave zeroed data behind
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
    end else if (en_s) begin
      out_vld_r  <= vld_d_s;
      out_data_r <= vld_d_s ? result_s : '0;
    end
  end

  // Merge counter and sticky error flag; a clear beats a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_cnt_r <= '0;
      multi_hit_r <= 1'b0;
    end else if (cnt_clr) begin
      merge_cnt_r <= '0;
      multi_hit_r <= 1'b0;
    end else begin
      if (accept_s && merge_s && (merge_cnt_r != {CNT_W{1'b1}})) begin
        merge_cnt_r <= merge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s && (l_multi_s || r_multi_s)) begin
        multi_hit_r <= 1'b1;
      end
    end
  end

  assign out_vld   = out_vld_r;
  assign out_data  = out_data_r;
  assign multi_hit = multi_hit_r;
  assign merge_cnt = merge_cnt_r;

endmodule

// File: tb/tb_fan_adder_node_pipe.sv
// Directed self-checking bench for fan_adder_node_pipe (NUM_IN=8, ADD_LAT=1).
// A second instance with SYMMETRY=1 shares all inputs.
module tb_fan_adder_node_pipe;

  localparam int DW_LINE = 136;
  localparam int NW      = 8 * DW_LINE;

  logic          clk, rst, in_vld, out_rdy, cnt_clr;
  logic [NW-1:0] in_data;
  logic          in_rdy, out_vld, multi_hit;
  logic [NW-1:0] out_data;
  logic [15:0]   merge_cnt;
  logic          in_rdy_s, out_vld_s, multi_hit_s;
  logic [NW-1:0] out_data_s;
  logic [15:0]   merge_cnt_s;

  int checks = 0;
  int passes = 0;

  fan_adder_node_pipe #(.SYMMETRY(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .multi_hit(multi_hit), .merge_cnt(merge_cnt), .cnt_clr(cnt_clr)
  );

  fan_adder_node_pipe #(.SYMMETRY(1)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy_s),
    .out_data(out_data_s), .out_vld(out_vld_s), .out_rdy(out_rdy),
    .multi_hit(multi_hit_s), .merge_cnt(merge_cnt_s), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW_LINE-1:0] mk(input logic [3:0] c, input logic [3:0] r,
      input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    return {c, r, w3, w2, w1, w0};
  endfunction

  // Drive one beat, then sample the result two cycles after acceptance
  task automatic run_beat(input logic [NW-1:0] d, output logic [NW-1:0] g,
                          output logic [NW-1:0] gs, output logic gv);
    @(negedge clk); in_data = d; in_vld = 1'b1;
    @(negedge clk); in_vld = 1'b0; in_data = '0;
    @(negedge clk); g = out_data; gs = out_data_s; gv = out_vld;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got %b want 0", out_vld); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else passes++;
    checks++; if (multi_hit !== 1'b0) $display("FAIL reset_multi_hit got %b want 0", multi_hit); else passes++;
    checks++; if (merge_cnt !== 16'd0) $display("FAIL reset_merge_cnt got %0d want 0", merge_cnt); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy got %b want 1", in_rdy); else passes++;
  endtask

  task automatic test_plain_merge();
    logic [NW-1:0] d, e, es, g, gs; logic gv;
    d = '0; e = '0; es = '0;
    d[1*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    d[6*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    e[3*DW_LINE +: DW_LINE]  = mk(4'b1000, 4'd3, 32'd11, 32'd22, 32'd33, 32'd44);
    es[4*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd11, 32'd22, 32'd33, 32'd44);
    run_beat(d, g, gs, gv);
    checks++; if (gv !== 1'b1) $display("FAIL plain_vld got %b want 1", gv); else passes++;
    checks++; if (g !== e) $display("FAIL plain_data got %h want %h", g, e); else passes++;
    checks++; if (gs !== es) $display("FAIL plain_sym1_data got %h want %h", gs, es); else passes++;
    checks++; if (merge_cnt !== 16'd1) $display("FAIL plain_cnt got %0d want 1", merge_cnt); else passes++;
  endtask

  task automatic test_row_mismatch();
    logic [NW-1:0] d, g, gs; logic gv;
    d = '0;
    d[1*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    d[6*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd5, 32'd10, 32'd20, 32'd30, 32'd40);
    run_beat(d, g, gs, gv);
    checks++; if (g !== d) $display("FAIL mismatch_bypass got %h want %h", g, d); else passes++;
    checks++; if (merge_cnt !== 16'd1) $display("FAIL mismatch_cnt got %0d want 1", merge_cnt); else passes++;
  endtask

  task automatic test_edge_codes();
    logic [NW-1:0] d, e, g, gs; logic gv;
    // L dir=01, R dir=10 -> left slot, code 0111
    d = '0; e = '0;
    d[1*DW_LINE +: DW_LINE] = mk(4'b1001, 4'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    d[6*DW_LINE +: DW_LINE] = mk(4'b1010, 4'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    e[3*DW_LINE +: DW_LINE] = mk(4'b0111, 4'd3, 32'd11, 32'd22, 32'd33, 32'd44);
    run_beat(d, g, gs, gv);
    checks++; if (g !== e) $display("FAIL code_lr got %h want %h", g, e); else passes++;
    // L dir=01 only -> right slot, code 1001
    d = '0; e = '0;
    d[0*DW_LINE +: DW_LINE] = mk(4'b1001, 4'd9, 32'd5, 32'd0, 32'd0, 32'd7);
    d[7*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd9, 32'd6, 32'd0, 32'd1, 32'd8);
    e[4*DW_LINE +: DW_LINE] = mk(4'b1001, 4'd9, 32'd11, 32'd0, 32'd1, 32'd15);
    run_beat(d, g, gs, gv);
    checks++; if (g !== e) $display("FAIL code_l got %h want %h", g, e); else passes++;
    // R dir=10 only -> left slot, code 1010 (same for both SYMMETRY settings)
    d = '0; e = '0;
    d[2*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd1, 32'd100, 32'd1, 32'd1, 32'd1);
    d[5*DW_LINE +: DW_LINE] = mk(4'b1010, 4'd1, 32'd23, 32'd2, 32'd3, 32'd4);
    e[3*DW_LINE +: DW_LINE] = mk(4'b1010, 4'd1, 32'd123, 32'd3, 32'd4, 32'd5);
    run_beat(d, g, gs, gv);
    checks++; if (g !== e) $display("FAIL code_r got %h want %h", g, e); else passes++;
    checks++; if (gs !== e) $display("FAIL code_r_sym1 got %h want %h", gs, e); else passes++;
    checks++; if (merge_cnt !== 16'd4) $display("FAIL codes_cnt got %0d want 4", merge_cnt); else passes++;
  endtask

  task automatic test_keep_wrap();
    logic [NW-1:0] d, e, g, gs; logic gv;
    d = '0; e = '0;
    d[0*DW_LINE +: DW_LINE] = mk(4'b0100, 4'd0, 32'hAB, 32'd0, 32'd0, 32'd0);
    d[7*DW_LINE +: DW_LINE] = mk(4'b0000, 4'd0, 32'hCD, 32'd0, 32'd0, 32'd0);
    d[2*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd7, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0);
    d[5*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd7, 32'd2, 32'd6, 32'd0, 32'd0);
    e[0*DW_LINE +: DW_LINE] = mk(4'b0100, 4'd0, 32'hAB, 32'd0, 32'd0, 32'd0);
    e[3*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd7, 32'd1, 32'd11, 32'd0, 32'd0);
    run_beat(d, g, gs, gv);
    checks++; if (g[0*DW_LINE +: DW_LINE] !== e[0*DW_LINE +: DW_LINE])
      $display("FAIL keep_lane0 got %h want %h", g[0*DW_LINE +: DW_LINE], e[0*DW_LINE +: DW_LINE]); else passes++;
    checks++; if (g[3*DW_LINE +: DW_LINE] !== e[3*DW_LINE +: DW_LINE])
      $display("FAIL wrap_sum got %h want %h", g[3*DW_LINE +: DW_LINE], e[3*DW_LINE +: DW_LINE]); else passes++;
    checks++; if (g !== e) $display("FAIL keep_wrap_all got %h want %h", g, e); else passes++;
    checks++; if (merge_cnt !== 16'd5) $display("FAIL keep_cnt got %0d want 5", merge_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] d, e;
    int sent, got, cyc, stalls;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    checks++; if (merge_cnt !== 16'd0) $display("FAIL bp_clr_cnt got %0d want 0", merge_cnt); else passes++;
    sent = 0; got = 0; cyc = 0; stalls = 0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      out_rdy = !(cyc >= 4 && cyc < 7);
      if (sent < 6) begin
        d = '0;
        d[1*DW_LINE +: DW_LINE] = mk(4'b1000, 4'(sent + 1), 32'(sent), 32'd1, 32'd2, 32'd3);
        d[6*DW_LINE +: DW_LINE] = mk(4'b1000, 4'(sent + 1), 32'd100, 32'd10, 32'd20, 32'd30);
        in_data = d; in_vld = 1'b1;
      end else begin
        in_data = '0; in_vld = 1'b0;
      end
      #1;
      if (!out_rdy && out_vld) begin
        stalls++;
        checks++; if (in_rdy !== 1'b0) $display("FAIL bp_in_rdy cycle %0d got %b want 0", cyc, in_rdy); else passes++;
      end
      if (out_vld && out_rdy) begin
        e = '0;
        e[3*DW_LINE +: DW_LINE] = mk(4'b1000, 4'(got + 1), 32'(got + 100), 32'd11, 32'd22, 32'd33);
        checks++; if (out_data !== e) $display("FAIL bp_order beat %0d got %h want %h", got, out_data, e); else passes++;
        got++;
      end
      if (in_vld && in_rdy) sent++;
    end
    @(negedge clk); in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
    checks++; if (got !== 6) $display("FAIL bp_timeout got %0d beats want 6", got); else passes++;
    checks++; if (stalls !== 3) $display("FAIL bp_stall_cycles got %0d want 3", stalls); else passes++;
    checks++; if (merge_cnt !== 16'd6) $display("FAIL bp_cnt got %0d want 6", merge_cnt); else passes++;
  endtask

  task automatic test_errors_reset();
    logic [NW-1:0] d, m, g, gs; logic gv;
    int stale;
    checks++; if (multi_hit !== 1'b0) $display("FAIL err_pre got %b want 0", multi_hit); else passes++;
    d = '0;
    d[0*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd2, 32'd1, 32'd0, 32'd0, 32'd0);
    d[2*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd2, 32'd2, 32'd0, 32'd0, 32'd0);
    run_beat(d, g, gs, gv);
    checks++; if (multi_hit !== 1'b1) $display("FAIL err_set got %b want 1", multi_hit); else passes++;
    checks++; if (g !== d) $display("FAIL err_bypass got %h want %h", g, d); else passes++;
    m = '0;
    m[1*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    m[6*DW_LINE +: DW_LINE] = mk(4'b1000, 4'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    run_beat(m, g, gs, gv);
    checks++; if (multi_hit !== 1'b1) $display("FAIL err_sticky got %b want 1", multi_hit); else passes++;
    checks++; if (merge_cnt !== 16'd7) $display("FAIL err_cnt got %0d want 7", merge_cnt); else passes++;
    // Clear and merge on the same edge
    @(negedge clk); in_data = m; in_vld = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); in_vld = 1'b0; in_data = '0; cnt_clr = 1'b0;
    checks++; if (merge_cnt !== 16'd0) $display("FAIL clr_win_cnt got %0d want 0", merge_cnt); else passes++;
    checks++; if (multi_hit !== 1'b0) $display("FAIL clr_win_mh got %b want 0", multi_hit); else passes++;
    repeat (2) @(negedge clk);
    // Two beats in flight when reset hits
    @(negedge clk); in_data = m; in_vld = 1'b1;
    @(negedge clk); in_data = d;
    @(negedge clk); in_vld = 1'b0; in_data = '0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (out_vld !== 1'b0) $display("FAIL rst_flush_vld got %b want 0", out_vld); else passes++;
    checks++; if (out_data !== '0) $display("FAIL rst_flush_data got %h want 0", out_data); else passes++;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_vld !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) $display("FAIL rst_stale got %0d valid cycles want 0", stale); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL rst_in_rdy got %b want 1", in_rdy); else passes++;
  endtask

  initial begin
    test_reset();
    test_plain_merge();
    test_row_mismatch();
    test_edge_codes();
    test_keep_wrap();
    test_backpressure();
    test_errors_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
